max_pool_2_bram_reader: RTL and testbench
=========================================

# max_pool_2_bram_reader

Read-side master for the max-pool-2 output buffer's dual-port BRAM. On a start command it issues sequential 32-bit reads on one BRAM port and streams the words to the Conv2D_2 input stage over a valid/ready interface. A credit-limited FIFO absorbs BRAM read latency so full throughput is kept without ever losing data under backpressure.

## Interface
- RD_LAT, 1: BRAM read latency in cycles; legal values are 1 or 2.
- FIFO_DEPTH, RD_LAT+2: depth of the output skid FIFO.
- CNT_W, 16: width of the word-count field.

- clk  in  1  single clock for all logic; also drives the BRAM port clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle command strobe; ignored while busy
- base_addr  in  32  byte address of the first word; bits [1:0] are ignored and treated as 0
- num_words  in  CNT_W  number of 32-bit words to read; 0 is legal
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse when a transfer completes
- bram_addr  out  32  BRAM byte address
- bram_en  out  1  BRAM enable; one read per cycle it is high
- bram_we  out  4  write enables; tied to 0
- bram_din  out  32  write data; tied to 0
- bram_dout  in  32  read data, valid RD_LAT cycles after the cycle in which bram_en was high
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  32  stream data
- m_last  out  1  high together with m_valid on the final word

## Operation
- States:
  - IDLE: waits for start.
  - ISSUE: issues reads.
  - DRAIN: all reads issued; waits for the final handshake.
  - DONE: single cycle, then returns to IDLE.
- IDLE -> ISSUE on start when num_words > 0.
  - Latch base_addr & ~3 into addr_q.
  - Latch num_words into issue_left and pop_left.
- IDLE -> DONE on start when num_words == 0. No BRAM access occurs and no stream beat is produced.
- ISSUE behaviour:
  - bram_en = (issue_left != 0) && (outstanding + fifo_count < FIFO_DEPTH).
  - outstanding counts reads issued but not yet returned.
  - Each issued read: addr_q += 4 (wraps modulo 2^32), issue_left -= 1.
- ISSUE -> DRAIN when issue_left reaches 0.
- Returning data is pushed into the FIFO RD_LAT cycles after its issue cycle. A push can never find the FIFO full, because the credit check above guarantees space.
- m_valid = FIFO not empty. m_data = FIFO head.
- A handshake (m_valid && m_ready) pops the FIFO and decrements pop_left.
- m_last = m_valid && (pop_left == 1).
- DRAIN -> DONE on the handshake where pop_left reaches 0.
- busy = state is ISSUE or DRAIN. done = state is DONE.
- start is ignored while busy or in DONE.
- bram_addr = addr_q, driven only while bram_en is high. It holds its value otherwise.
- Reset values: state IDLE; busy, done, bram_en, m_valid, m_last all 0; bram_addr 0; FIFO empty; all counters 0.
- Reset asserted mid-transfer:
  - Clears everything immediately.
  - In-flight read data arriving after reset release is discarded, because outstanding = 0 and no push occurs.
- m_ready may toggle freely. m_data and m_last hold stable while m_valid is high and m_ready is low.

## Timing
- start sampled at edge 0:
  - busy and the first bram_en are high in cycle 1.
  - bram_dout for that read is valid in cycle 1+RD_LAT.
  - m_valid is first high in cycle 2+RD_LAT.
- With m_ready held high: one word per cycle, no bubbles after the first.
- For N words with m_ready high, the final handshake occurs in cycle N+1+RD_LAT.
- done pulses in the cycle after the final handshake; busy falls in that same cycle.
- With num_words = 0: done pulses in cycle 1 and busy stays low.
- A new start is accepted in the cycle after the done pulse.
- Simultaneous FIFO push and pop in one cycle: fifo_count is unchanged.

## Structure
- Shared package max_pool_2_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - BRAM_DATA_W = 32, BRAM_ADDR_W = 32, WORD_BYTES = 4.
- Sub-module bram_rd_fifo: synchronous FIFO, DATA_W × FIFO_DEPTH, with push, pop, head data, empty flag and count output.
- Top level holds the FSM, the address and word counters, the outstanding counter and the credit logic.

## Test plan
- base_addr=0x100, num_words=4, m_ready=1, RD_LAT=1:
  - bram_addr sequence 0x100, 0x104, 0x108, 0x10C in cycles 1-4;
  - m_data equals the BRAM preload in order, in cycles 3-6;
  - m_last high in cycle 6; done in cycle 7.
- num_words=0: done pulses in cycle 1; bram_en and m_valid never assert.
- num_words=16 with m_ready random at 50%:
  - all 16 words delivered in order, none duplicated;
  - bram_en never issued when outstanding + fifo_count = FIFO_DEPTH.
- RD_LAT=2, num_words=8, m_ready low for cycles 3-10 and then high:
  - no data lost;
  - FIFO never overflows;
  - the stream resumes 1 word/cycle.
- base_addr=0xFFFFFFF8, num_words=4: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst_n pulsed low mid-transfer (after 3 of 8 words):
  - all outputs return to their reset values;
  - no stale m_valid after release;
  - a new start with num_words=2 completes correctly.

Source files
------------

// File: rtl/max_pool_2_pkg.sv
// Shared types and constants for the max-pool-2 output buffer read path.
// Imported by the BRAM reader and its skid FIFO.
package max_pool_2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_ADDR_W = 32;
    localparam int WORD_BYTES  = 4;

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO that absorbs BRAM read latency in front of
// the output stream. Handles non-power-of-two depths.
module bram_rd_fifo #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 3,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/max_pool_2_bram_reader.sv
// Sequential BRAM read master streaming max-pool-2 output words to Conv2D_2.
// Reads are credit-limited so the skid FIFO can never overflow.
module max_pool_2_bram_reader
    import max_pool_2_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = RD_LAT + 2,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BRAM_ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]       num_words,
    output logic                   busy,
    output logic                   done,
    output logic [BRAM_ADDR_W-1:0] bram_addr,
    output logic                   bram_en,
    output logic [WORD_BYTES-1:0]  bram_we,
    output logic [BRAM_DATA_W-1:0] bram_din,
    input  logic [BRAM_DATA_W-1:0] bram_dout,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [BRAM_DATA_W-1:0] m_data,
    output logic                   m_last
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    state_e                 state_q, state_d;
    logic [BRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [BRAM_ADDR_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]       issue_left_q, issue_left_d;
    logic [CNT_W-1:0]       pop_left_q, pop_left_d;
    logic [OCC_W-1:0]       outst_q, outst_d;
    logic [RD_LAT-1:0]      rd_pipe_q, rd_pipe_d;

    logic [OCC_W-1:0]       fifo_count;
    logic [OCC_W:0]         occ_sum;
    logic                   fifo_empty;
    logic                   credit_ok;
    logic                   rd_en;
    logic                   push;
    logic                   hs;

    // Occupancy counts both in-flight reads and buffered words.
    assign occ_sum   = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok = occ_sum < (OCC_W + 1)'(FIFO_DEPTH);
    assign rd_en     = (state_q == ISSUE) && (issue_left_q != '0) && credit_ok;
    assign push      = rd_pipe_q[RD_LAT-1];
    assign hs        = m_valid && m_ready;

    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign bram_en   = rd_en;
    assign bram_addr = rd_en ? addr_q : hold_q;
    assign bram_we   = '0;
    assign bram_din  = '0;
    assign m_valid   = !fifo_empty;
    assign m_last    = m_valid && (pop_left_q == CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        hold_d       = hold_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        outst_d      = outst_q;
        rd_pipe_d    = rd_pipe_q << 1;
        rd_pipe_d[0] = rd_en;

        if (rd_en) begin
            addr_d       = addr_q + BRAM_ADDR_W'(WORD_BYTES);
            hold_d       = addr_q;
            issue_left_d = issue_left_q - 1'b1;
        end
        if (hs) pop_left_d = pop_left_q - 1'b1;

        case ({rd_en, push})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d      = ISSUE;
                        addr_d       = {base_addr[BRAM_ADDR_W-1:2], 2'b00};
                        issue_left_d = num_words;
                        pop_left_d   = num_words;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: if (issue_left_d == '0) state_d = DRAIN;
            DRAIN: if (hs && pop_left_q == CNT_W'(1)) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            hold_q       <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            outst_q      <= '0;
            rd_pipe_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hold_q       <= hold_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            outst_q      <= outst_d;
            rd_pipe_q    <= rd_pipe_d;
        end
    end

    bram_rd_fifo #(
        .DATA_W (BRAM_DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bram_dout),
        .pop       (hs),
        .head      (m_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_max_pool_2_bram_reader.sv
// Bench for max_pool_2_bram_reader: RD_LAT=1 and RD_LAT=2 instances run the
// same commands side by side against a scoreboard of expected stream words.
module tb_max_pool_2_bram_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic        m_ready = 1'b0;
    logic [31:0] dout0, dout1, pipe1;

    wire  [1:0]  busy_v, done_v, en_v, mv_v, ml_v;
    wire  [31:0] addr_v [2];
    wire  [31:0] data_v [2];
    wire  [31:0] din_v [2];
    wire  [3:0]  we_v [2];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          issued [2] = '{0, 0};
    int          popped [2] = '{0, 0};
    logic [32:0] sb0 [$];
    logic [32:0] sb1 [$];

    always #5 clk = ~clk;

    max_pool_2_bram_reader #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .num_words(num_words),
        .busy(busy_v[0]), .done(done_v[0]),
        .bram_addr(addr_v[0]), .bram_en(en_v[0]),
        .bram_we(we_v[0]), .bram_din(din_v[0]), .bram_dout(dout0),
        .m_valid(mv_v[0]), .m_ready(m_ready),
        .m_data(data_v[0]), .m_last(ml_v[0])
    );

    max_pool_2_bram_reader #(.RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .num_words(num_words),
        .busy(busy_v[1]), .done(done_v[1]),
        .bram_addr(addr_v[1]), .bram_en(en_v[1]),
        .bram_we(we_v[1]), .bram_din(din_v[1]), .bram_dout(dout1),
        .m_valid(mv_v[1]), .m_ready(m_ready),
        .m_data(data_v[1]), .m_last(ml_v[1])
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    // BRAM models; non-read cycles return junk so misaligned pushes show up.
    always @(posedge clk) begin
        dout0 <= en_v[0] ? mem_word(addr_v[0]) : 32'hDEAD_BEEF;
        pipe1 <= en_v[1] ? mem_word(addr_v[1]) : 32'hDEAD_BEEF;
        dout1 <= pipe1;
    end

    // Stream scoreboard and credit monitor.
    always @(negedge clk) begin
        logic [32:0] exp_w;
        int          sz;
        if (!rst_n) begin
            issued = '{0, 0};
            popped = '{0, 0};
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (en_v[d]) begin
                    n_cmp++;
                    if (issued[d] - popped[d] >= d + 3) begin
                        n_bad++;
                        $display("FAIL credit dut%0d: in_flight=%0d required<%0d",
                                 d, issued[d] - popped[d], d + 3);
                    end
                    issued[d]++;
                end
                if (mv_v[d] && m_ready) begin
                    popped[d]++;
                    n_cmp++;
                    sz = (d == 0) ? sb0.size() : sb1.size();
                    if (sz == 0) begin
                        n_bad++;
                        $display("FAIL extra_beat dut%0d: got data=%h last=%b, required none",
                                 d, data_v[d], ml_v[d]);
                    end else begin
                        exp_w = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                        if ({ml_v[d], data_v[d]} !== exp_w) begin
                            n_bad++;
                            $display("FAIL beat dut%0d: got last=%b data=%h, required last=%b data=%h",
                                     d, ml_v[d], data_v[d], exp_w[32], exp_w[31:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a command; returns just after edge 0, i.e. inside cycle 1.
    task automatic go(input logic [31:0] base, input logic [15:0] n);
        logic [32:0] e;
        step();
        start     = 1'b1;
        base_addr = base;
        num_words = n;
        for (int i = 0; i < int'(n); i++) begin
            e = {(i == int'(n) - 1), mem_word({base[31:2], 2'b00} + 32'(4 * i))};
            sb0.push_back(e);
            sb1.push_back(e);
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit rnd);
        logic [1:0] seen = '0;
        int         c = 0;
        while (seen != 2'b11 && c < limit) begin
            @(negedge clk);
            seen |= done_v;
            c++;
            step();
            if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
        n_cmp++;
        if (seen != 2'b11) begin
            n_bad++;
            $display("FAIL done_timeout: done seen=%b, required 11", seen);
        end
        n_cmp++;
        if (sb0.size() + sb1.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: words undelivered=%0d/%0d, required 0/0",
                     sb0.size(), sb1.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({busy_v[d], done_v[d], en_v[d], mv_v[d], ml_v[d]} !== 5'b0 ||
                addr_v[d] !== 32'h0 || we_v[d] !== 4'h0 || din_v[d] !== 32'h0) begin
                n_bad++;
                $display("FAIL %s dut%0d: busy/done/en/valid/last=%b%b%b%b%b addr=%h we=%h din=%h, required all 0",
                         tag, d, busy_v[d], done_v[d], en_v[d], mv_v[d], ml_v[d],
                         addr_v[d], we_v[d], din_v[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int L;
        m_ready = 1'b1;
        go(32'h100, 16'd4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                L = d + 1;
                n_cmp++;
                if (en_v[d] !== (c <= 4) ||
                    addr_v[d] !== ((c <= 4) ? 32'h100 + 32'(4 * (c - 1)) : 32'h10C)) begin
                    n_bad++;
                    $display("FAIL basic_addr dut%0d c%0d: en=%b addr=%h, required en=%b addr=%h",
                             d, c, en_v[d], addr_v[d], (c <= 4),
                             (c <= 4) ? 32'h100 + 32'(4 * (c - 1)) : 32'h10C);
                end
                n_cmp++;
                if ({mv_v[d], ml_v[d], done_v[d], busy_v[d]} !==
                    {(c >= 2 + L && c <= 5 + L), (c == 5 + L), (c == 6 + L), (c <= 5 + L)}) begin
                    n_bad++;
                    $display("FAIL basic_ctl dut%0d c%0d: valid/last/done/busy=%b%b%b%b, required %b%b%b%b",
                             d, c, mv_v[d], ml_v[d], done_v[d], busy_v[d],
                             (c >= 2 + L && c <= 5 + L), (c == 5 + L), (c == 6 + L), (c <= 5 + L));
                end
            end
            step();
        end
        n_cmp++;
        if (sb0.size() + sb1.size() != 0) begin
            n_bad++;
            $display("FAIL basic_left: undelivered=%0d/%0d, required 0/0", sb0.size(), sb1.size());
        end
    endtask

    task automatic test_zero();
        go(32'h40, 16'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (done_v !== ((c == 1) ? 2'b11 : 2'b00) || busy_v !== 2'b00 ||
                en_v !== 2'b00 || mv_v !== 2'b00) begin
                n_bad++;
                $display("FAIL zero c%0d: done=%b busy=%b en=%b valid=%b, required done=%b others 00",
                         c, done_v, busy_v, en_v, mv_v, (c == 1) ? 2'b11 : 2'b00);
            end
            step();
        end
    endtask

    task automatic test_random_ready();
        m_ready = 1'($urandom_range(0, 1));
        go(32'h1000, 16'd16);
        wait_done(300, 1'b1);
        m_ready = 1'b1;
    endtask

    task automatic test_backpressure();
        m_ready = 1'b1;
        go(32'h2000, 16'd8);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c >= 11 && c <= 18) begin
                n_cmp++;
                if (mv_v !== 2'b11 || ml_v !== ((c == 18) ? 2'b11 : 2'b00)) begin
                    n_bad++;
                    $display("FAIL bp_stream c%0d: valid=%b last=%b, required valid=11 last=%b",
                             c, mv_v, ml_v, (c == 18) ? 2'b11 : 2'b00);
                end
            end
            if (c == 19) begin
                n_cmp++;
                if (done_v !== 2'b11) begin
                    n_bad++;
                    $display("FAIL bp_done c19: done=%b, required 11", done_v);
                end
            end
            step();
            m_ready = !((c + 1) >= 3 && (c + 1) <= 10);
        end
        n_cmp++;
        if (sb0.size() + sb1.size() != 0) begin
            n_bad++;
            $display("FAIL bp_left: undelivered=%0d/%0d, required 0/0", sb0.size(), sb1.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea;
        m_ready = 1'b1;
        go(32'hFFFF_FFF8, 16'd4);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            ea = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (en_v[d] !== 1'b1 || addr_v[d] !== ea) begin
                    n_bad++;
                    $display("FAIL wrap dut%0d c%0d: en=%b addr=%h, required en=1 addr=%h",
                             d, c, en_v[d], addr_v[d], ea);
                end
            end
            step();
        end
        wait_done(30, 1'b0);
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        go(32'h3000, 16'd8);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            step();
        end
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        @(negedge clk);
        check_idle_outputs("mid_reset");
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (mv_v !== 2'b00 || en_v !== 2'b00 || busy_v !== 2'b00) begin
                n_bad++;
                $display("FAIL post_reset c%0d: valid=%b en=%b busy=%b, required 00",
                         c, mv_v, en_v, busy_v);
            end
            step();
        end
        go(32'h3100, 16'd2);
        wait_done(30, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_random_ready();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
